hlsm_param_loop: RTL

HLSM_PARAM_LOOP -- requirements
Module: hlsm_param_loop

---
 rtl/hlsm_param_loop.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hlsm_param_loop.sv
// Iterative subtract/add loop controller: runs cnt iterations of
// "if a > d then a -= d else d += k" and reports W = a + d with an overflow flag.
module hlsm_param_loop #(
  parameter int DATAW  = 32,
  parameter int CNTW   = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [DATAW-1:0] x0,
  input  logic [DATAW-1:0] y0,
  input  logic [DATAW-1:0] k,
  input  logic [CNTW-1:0]  cnt,
  output logic             Done,
  output logic             Busy,
  output logic [DATAW-1:0] W,
  output logic             Ovf
);

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_LOAD,
    ST_CHK,
    ST_CMP,
    ST_SUB,
    ST_ADD,
    ST_INC,
    ST_OUT,
    ST_FINAL
  } state_t;

  state_t state, state_n;

  logic [DATAW-1:0] a, d, kr;
  logic [CNTW-1:0]  cr, i;

  logic [DATAW-1:0] sub_res, add_res, out_res;
  logic             add_c, out_c, sub_b;
  logic             sub_v, add_v, out_v;
  logic             ovf_sub, ovf_add, ovf_out;
  logic             a_gt_d;
  logic [CNTW-1:0]  i_inc;
  logic             last_iter;

  // Arithmetic with carry/borrow for unsigned mode and sign-overflow for signed mode.
  assign {add_c, add_res} = {1'b0, d} + {1'b0, kr};
  assign {out_c, out_res} = {1'b0, a} + {1'b0, d};
  assign sub_res          = a - d;
  assign sub_b            = (a < d);

  assign sub_v = (a[DATAW-1] != d[DATAW-1])  && (sub_res[DATAW-1] != a[DATAW-1]);
  assign add_v = (d[DATAW-1] == kr[DATAW-1]) && (add_res[DATAW-1] != d[DATAW-1]);
  assign out_v = (a[DATAW-1] == d[DATAW-1])  && (out_res[DATAW-1] != a[DATAW-1]);

  assign ovf_sub = SIGNED ? sub_v : sub_b;
  assign ovf_add = SIGNED ? add_v : add_c;
  assign ovf_out = SIGNED ? out_v : out_c;

  assign a_gt_d = SIGNED ? ($signed(a) > $signed(d)) : (a > d);

  // i only increments while i < cr, so i_inc never wraps even for cr = 2^CNTW-1.
  assign i_inc     = i + CNTW'(1);
  assign last_iter = (i_inc == cr);

  assign Busy = (state != ST_WAIT);

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_WAIT;
    else     state <= state_n;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      ST_WAIT:  if (Start) state_n = ST_LOAD;
      ST_LOAD:  state_n = ST_CHK;
      ST_CHK:   state_n = (i == cr) ? ST_OUT : ST_CMP;
      ST_CMP:   state_n = a_gt_d ? ST_SUB : ST_ADD;
      ST_SUB:   state_n = ST_INC;
      ST_ADD:   state_n = ST_INC;
      // INC resolves the loop check itself so an iteration costs three cycles;
      // CHK is only traversed once, right after LOAD.
      ST_INC:   state_n = last_iter ? ST_OUT : ST_CMP;
      ST_OUT:   state_n = ST_FINAL;
      ST_FINAL: state_n = ST_WAIT;
      default:  state_n = ST_WAIT;
    endcase
  end

  // NOTE: registers use <= so every update in a cycle sees the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a    <= '0;
      d    <= '0;
      kr   <= '0;
      cr   <= '0;
      i    <= '0;
      W    <= '0;
      Ovf  <= 1'b0;
      Done <= 1'b0;
    end else begin
      case (state)
        ST_WAIT:  Done <= 1'b0;
        ST_LOAD: begin
          a   <= x0;
          d   <= y0;
          kr  <= k;
          cr  <= cnt;
          i   <= '0;
          Ovf <= 1'b0;
        end
        ST_SUB: begin
          a   <= sub_res;
          Ovf <= Ovf | ovf_sub;
        end
        ST_ADD: begin
          d   <= add_res;
          Ovf <= Ovf | ovf_add;
        end
        ST_INC:   i <= i_inc;
        ST_OUT: begin
          W   <= out_res;
          Ovf <= Ovf | ovf_out;
        end
        ST_FINAL: Done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
